// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch port: request/address from the fetch controller,
// ready/instruction word back from memory.
interface pc_fetch_ctrl_if #(
    parameter int unsigned ADDRESS_WIDTH = 32
);
    localparam int unsigned DATA_WIDTH = 32;

    logic                     imem_req_o;
    logic [ADDRESS_WIDTH-1:0] imem_addr_o;
    logic                     imem_ready_i;
    logic [DATA_WIDTH-1:0]    imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives PC_next for the external pc_counter, runs the
// imem req/ready handshake and delivers PC-tagged instructions to decode.
module pc_fetch_ctrl #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
    parameter int unsigned              INSTR_BYTES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    output logic [ADDRESS_WIDTH-1:0] PC_next,
    input  logic                     stall_i,
    input  logic                     redirect_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_addr_i,
    pc_fetch_ctrl_if.master          imem,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [ADDRESS_WIDTH-1:0] instr_pc_o
);
    localparam int unsigned              DATA_WIDTH = 32;
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(INSTR_BYTES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                   state_q;
    state_e                   state_d;
    logic                     pending_q;
    logic [ADDRESS_WIDTH-1:0] target_q;

    logic                     req_c;
    logic                     accept_c;
    logic                     deliver_c;
    logic [ADDRESS_WIDTH-1:0] redirect_aligned_c;
    logic [ADDRESS_WIDTH-1:0] accept_pc_c;

    assign redirect_aligned_c = redirect_addr_i & ~ALIGN_MASK;

    // Where the PC goes once the current fetch is accepted: live redirect,
    // then a redirect remembered during the wait, then the next sequential word.
    assign accept_pc_c = redirect_valid_i ? redirect_aligned_c :
                         pending_q        ? target_q           :
                                            pc_i + PC_STEP;

    assign accept_c  = req_c & imem.imem_ready_i;
    assign deliver_c = accept_c & ~redirect_valid_i & ~pending_q;

    assign imem.imem_req_o  = req_c;
    assign imem.imem_addr_o = pc_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ:  if (req_c && !imem.imem_ready_i) state_d = ST_WAIT;
            ST_WAIT: if (imem.imem_ready_i) state_d = ST_REQ;
            default: state_d = ST_BOOT;
        endcase
    end

    // Outstanding fetches in WAIT ignore stall so the memory transaction completes.
    always_comb begin
        req_c   = 1'b0;
        PC_next = RESET_VECTOR;
        case (state_q)
            ST_BOOT: begin
                req_c   = 1'b0;
                PC_next = RESET_VECTOR;
            end
            ST_REQ: begin
                if (redirect_valid_i) begin
                    PC_next = redirect_aligned_c;
                end else if (stall_i) begin
                    PC_next = pc_i;
                end else begin
                    req_c   = 1'b1;
                    PC_next = imem.imem_ready_i ? accept_pc_c : pc_i;
                end
            end
            ST_WAIT: begin
                req_c   = 1'b1;
                PC_next = imem.imem_ready_i ? accept_pc_c : pc_i;
            end
            default: begin
                req_c   = 1'b0;
                PC_next = RESET_VECTOR;
            end
        endcase
    end

    // A redirect arriving while waiting is held until the fetch is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= 1'b0;
            target_q  <= '0;
        end else if (accept_c) begin
            pending_q <= 1'b0;
        end else if (state_q == ST_WAIT && redirect_valid_i) begin
            pending_q <= 1'b1;
            target_q  <= redirect_aligned_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
        end else begin
            instr_valid_o <= deliver_c;
            if (deliver_c) begin
                instr_o    <= DATA_WIDTH'(imem.imem_rdata_i);
                instr_pc_o <= pc_i;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, corner-case sequences and
// random traffic checked against a transaction-level fetch model.
module tb_pc_fetch_ctrl;
    localparam int unsigned    AW = 32;
    localparam logic [AW-1:0]  RV = 32'h0000_0000;
    localparam int unsigned    IB = 4;
    localparam int unsigned    NV = 31;

    typedef struct {
        logic          stall;
        logic          rv;
        logic [AW-1:0] ra;
        logic          ready;
        logic [31:0]   rdata;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic [AW-1:0] e_next;
        logic          e_valid;
        logic [AW-1:0] e_ipc;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_q = 32'hDEAD_BEE0;
    logic [AW-1:0] pc_next;
    logic          stall, redir_v, ready;
    logic [AW-1:0] redir_a;
    logic [31:0]   rdata;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;

    int checks = 0;
    int errors = 0;

    // Reference model state: a fetch either is or is not outstanding, plus
    // the latest redirect seen while it was outstanding.
    bit            m_booted, m_busy, m_pend_v, m_valid;
    logic [AW-1:0] m_pend_a, m_ipc;
    logic [31:0]   m_instr;
    logic          e_req, e_deliver;
    logic [AW-1:0] e_next;

    vec_t vecs [NV];

    pc_fetch_ctrl_if #(.ADDRESS_WIDTH(AW)) imem_if ();

    assign imem_if.imem_ready_i = ready;
    assign imem_if.imem_rdata_i = rdata;

    pc_fetch_ctrl #(
        .ADDRESS_WIDTH (AW),
        .RESET_VECTOR  (RV),
        .INSTR_BYTES   (IB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_q),
        .PC_next          (pc_next),
        .stall_i          (stall),
        .redirect_valid_i (redir_v),
        .redirect_addr_i  (redir_a),
        .imem             (imem_if),
        .instr_valid_o    (instr_valid),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a - (a % AW'(IB));
    endfunction

    function automatic vec_t mk(input logic s, input logic rv, input logic [AW-1:0] ra,
                                input logic rd, input logic [31:0] d, input logic er,
                                input logic [AW-1:0] ea, input logic [AW-1:0] en,
                                input logic ev, input logic [AW-1:0] eipc);
        vec_t v;
        v.stall = s;  v.rv = rv;  v.ra = ra;  v.ready = rd;  v.rdata = d;
        v.e_req = er; v.e_addr = ea; v.e_next = en; v.e_valid = ev; v.e_ipc = eipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_booted = 0; m_busy = 0; m_pend_v = 0; m_pend_a = '0;
        m_valid = 0; m_instr = '0; m_ipc = '0;
    endtask

    task automatic model_eval();
        e_req = 1'b0; e_next = RV; e_deliver = 1'b0;
        if (rst && m_booted) begin
            if (m_busy || (!redir_v && !stall)) begin
                e_req = 1'b1;
                if (!ready)         e_next = pc_q;
                else if (redir_v)   e_next = align(redir_a);
                else if (m_pend_v)  e_next = m_pend_a;
                else begin
                    e_next    = pc_q + AW'(IB);
                    e_deliver = 1'b1;
                end
            end else if (redir_v) begin
                e_next = align(redir_a);
            end else begin
                e_next = pc_q;
            end
        end
    endtask

    task automatic apply(input logic s, input logic rv, input logic [AW-1:0] ra,
                         input logic rd, input logic [31:0] d);
        stall = s; redir_v = rv; redir_a = ra; ready = rd; rdata = d;
        @(negedge clk);
        model_eval();
        chk("req",      32'(imem_if.imem_req_o), 32'(e_req));
        chk("addr",     imem_if.imem_addr_o, pc_q);
        chk("pc_next",  pc_next, e_next);
        chk("valid",    32'(instr_valid), 32'(m_valid));
        chk("instr",    instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
    endtask

    task automatic tick();
        @(posedge clk);
        pc_q <= rst ? e_next : RV;
        if (!rst) begin
            model_reset();
        end else if (!m_booted) begin
            m_booted = 1;
            m_valid  = 0;
        end else begin
            m_valid = e_deliver;
            if (e_deliver) begin
                m_instr = rdata;
                m_ipc   = pc_q;
            end
            if (e_req && ready) begin
                m_busy = 0; m_pend_v = 0;
            end else if (e_req) begin
                if (m_busy && redir_v) begin
                    m_pend_v = 1;
                    m_pend_a = align(redir_a);
                end
                m_busy = 1;
            end
        end
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0,0,0,1,32'hA000_0000, 0,32'h000,32'h000,0,32'h000);
        vecs[1]  = mk(0,0,0,1,32'hA000_0001, 1,32'h000,32'h004,0,32'h000);
        vecs[2]  = mk(0,0,0,1,32'hA000_0002, 1,32'h004,32'h008,1,32'h000);
        vecs[3]  = mk(0,0,0,1,32'hA000_0003, 1,32'h008,32'h00C,1,32'h004);
        vecs[4]  = mk(0,0,0,1,32'hA000_0004, 1,32'h00C,32'h010,1,32'h008);
        vecs[5]  = mk(0,0,0,0,32'hA000_0005, 1,32'h010,32'h010,1,32'h00C);
        vecs[6]  = mk(0,0,0,0,32'hA000_0006, 1,32'h010,32'h010,0,32'h00C);
        vecs[7]  = mk(0,0,0,1,32'hA000_0007, 1,32'h010,32'h014,0,32'h00C);
        vecs[8]  = mk(1,0,0,1,32'hA000_0008, 0,32'h014,32'h014,1,32'h010);
        vecs[9]  = mk(0,0,0,1,32'hA000_0009, 1,32'h014,32'h018,0,32'h010);
        vecs[10] = mk(0,0,0,1,32'hA000_000A, 1,32'h018,32'h01C,1,32'h014);
        vecs[11] = mk(0,0,0,1,32'hA000_000B, 1,32'h01C,32'h020,1,32'h018);
        vecs[12] = mk(0,0,0,0,32'hA000_000C, 1,32'h020,32'h020,1,32'h01C);
        vecs[13] = mk(0,1,32'h103,0,32'hA000_000D, 1,32'h020,32'h020,0,32'h01C);
        vecs[14] = mk(0,0,0,0,32'hA000_000E, 1,32'h020,32'h020,0,32'h01C);
        vecs[15] = mk(0,0,0,1,32'hA000_000F, 1,32'h020,32'h100,0,32'h01C);
        vecs[16] = mk(0,0,0,1,32'hA000_0010, 1,32'h100,32'h104,0,32'h01C);
        vecs[17] = mk(0,0,0,0,32'hA000_0011, 1,32'h104,32'h104,1,32'h100);
        vecs[18] = mk(0,1,32'h080,0,32'hA000_0012, 1,32'h104,32'h104,0,32'h100);
        vecs[19] = mk(0,1,32'h040,1,32'hA000_0013, 1,32'h104,32'h040,0,32'h100);
        vecs[20] = mk(0,0,0,1,32'hA000_0014, 1,32'h040,32'h044,0,32'h100);
        vecs[21] = mk(0,0,0,1,32'hA000_0015, 1,32'h044,32'h048,1,32'h040);
        vecs[22] = mk(1,0,0,1,32'hA000_0016, 0,32'h048,32'h048,1,32'h044);
        vecs[23] = mk(1,0,0,1,32'hA000_0017, 0,32'h048,32'h048,0,32'h044);
        vecs[24] = mk(1,0,0,1,32'hA000_0018, 0,32'h048,32'h048,0,32'h044);
        vecs[25] = mk(0,0,0,0,32'hA000_0019, 1,32'h048,32'h048,0,32'h044);
        vecs[26] = mk(1,0,0,0,32'hA000_001A, 1,32'h048,32'h048,0,32'h044);
        vecs[27] = mk(1,0,0,1,32'hA000_001B, 1,32'h048,32'h04C,0,32'h044);
        vecs[28] = mk(1,0,0,1,32'hA000_001C, 0,32'h04C,32'h04C,1,32'h048);
        vecs[29] = mk(1,1,32'h207,1,32'hA000_001D, 0,32'h04C,32'h204,0,32'h048);
        vecs[30] = mk(0,0,0,1,32'hA000_001E, 1,32'h204,32'h208,0,32'h048);

        // Reset state
        rst = 1'b0;
        model_reset();
        apply(0, 0, '0, 1, '0);
        tick();
        apply(0, 0, '0, 1, '0);
        tick();
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < int'(NV); i++) begin
            apply(vecs[i].stall, vecs[i].rv, vecs[i].ra, vecs[i].ready, vecs[i].rdata);
            chk($sformatf("vec%0d_req", i),     32'(imem_if.imem_req_o), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d_addr", i),    imem_if.imem_addr_o, vecs[i].e_addr);
            chk($sformatf("vec%0d_next", i),    pc_next, vecs[i].e_next);
            chk($sformatf("vec%0d_valid", i),   32'(instr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_ipc", i),     instr_pc, vecs[i].e_ipc);
            tick();
        end

        // Wrap of the sequential increment
        apply(0, 1, 32'hFFFF_FFFF, 1, '0);
        chk("wrap_redirect", pc_next, 32'hFFFF_FFFC);
        tick();
        apply(0, 0, '0, 1, 32'hCAFE_F00D);
        chk("wrap_next", pc_next, 32'h0000_0000);
        tick();
        apply(0, 0, '0, 0, '0);
        chk("wrap_valid", 32'(instr_valid), 32'd1);
        chk("wrap_instr", instr, 32'hCAFE_F00D);
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        tick();

        // Asynchronous reset while a fetch is outstanding
        apply(0, 1, 32'h0000_0600, 0, '0);
        chk("wait_req", 32'(imem_if.imem_req_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(imem_if.imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_next", pc_next, RV);
        chk("rst_ipc", instr_pc, 32'd0);
        model_reset();
        tick();
        apply(0, 0, '0, 1, '0);
        tick();
        rst = 1'b1;
        apply(0, 0, '0, 1, '0);
        chk("boot_req", 32'(imem_if.imem_req_o), 32'd0);
        tick();
        apply(0, 0, '0, 1, 32'h1234_5678);
        chk("boot_fetch_addr", imem_if.imem_addr_o, RV);
        chk("boot_fetch_req", 32'(imem_if.imem_req_o), 32'd1);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic          s, rv, rd;
            logic [AW-1:0] ra;
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 6) == 0);
            rd = ($urandom_range(0, 1) == 1);
            ra = $urandom();
            if (($urandom_range(0, 15) == 0)) ra = 32'hFFFF_FFFD;
            apply(s, rv, ra, rd, $urandom());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
